// File: rtl/dwrr_queue_sched_pkg.sv
// Shared constants and helpers for the DWRR queue scheduler.
package dwrr_queue_sched_pkg;

  localparam int unsigned NUM_REQS_DEF = 4;
  localparam int unsigned WIDTH_DEF    = 8;
  localparam int unsigned DEPTH_DEF    = 8;
  localparam int unsigned QWID_DEF     = 8;
  localparam int unsigned MAX_REQS     = 32;

  // FIFO occupancy counter must represent 0..DEPTH inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // One spare bit so an accumulated quantum on top of residual credit cannot wrap.
  function automatic int unsigned def_w(input int unsigned qwid);
    return qwid + 1;
  endfunction

  function automatic logic [MAX_REQS-1:0] onehot(input int unsigned idx);
    logic [MAX_REQS-1:0] v;
    v = '0;
    if (idx < MAX_REQS) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dwrr_queue_sched_fifo.sv
// First-word-fall-through FIFO feeding one arbiter lane; storage is not reset.
module sched_fifo
  import dwrr_queue_sched_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Full is judged before the pop, so a push into a full queue is lost even if it pops.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1);
      if (do_pop)  rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/dwrr_queue_sched.sv
// DWRR scheduler over NUM_REQS FIFOs. Define DWRR_QUEUE_SCHED_BLK_EN to add the blk back-pressure port.
module dwrr_queue_sched
  import dwrr_queue_sched_pkg::*;
#(
  parameter int unsigned NUM_REQS = NUM_REQS_DEF,
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned QWID     = QWID_DEF,
  parameter int unsigned PSIZE    = WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQS-1:0]      push,
  input  logic [NUM_REQS*WIDTH-1:0] flat_data_in,
  input  logic [NUM_REQS*QWID-1:0] input_quantums,
`ifdef DWRR_QUEUE_SCHED_BLK_EN
  input  logic                     blk,
`endif
  output logic [NUM_REQS-1:0]      full,
  output logic [NUM_REQS-1:0]      empty,
  output logic [NUM_REQS-1:0]      gnt,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_out_vld
);

  localparam int unsigned DW = def_w(QWID);
  localparam int unsigned PW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  logic [WIDTH-1:0] heads   [NUM_REQS];
  logic [QWID-1:0]  quanta  [NUM_REQS];
  logic [DW-1:0]    deficit [NUM_REQS];
  logic [NUM_REQS-1:0] reqs;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    nxt;
  logic [DW-1:0]    nxt_base;
  logic             serve;
  logic             hold;

`ifdef DWRR_QUEUE_SCHED_BLK_EN
  assign hold = blk;
`else
  assign hold = 1'b0;
`endif

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_q
    sched_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push[g]),
      .pop  (gnt[g]),
      .din  (flat_data_in[g*WIDTH +: WIDTH]),
      .head (heads[g]),
      .full (full[g]),
      .empty(empty[g])
    );
    assign quanta[g] = input_quantums[g*QWID +: QWID];
  end

  assign reqs         = ~empty;
  assign data_out_vld = |gnt;

  // Grant decision and the credit seen by the next queue once an idle queue is cleared.
  always_comb begin
    serve    = 1'b0;
    gnt      = '0;
    data_out = '0;
    nxt      = (ptr == PW'(NUM_REQS - 1)) ? '0 : ptr + PW'(1);
    nxt_base = deficit[nxt];
    serve    = ~hold & reqs[ptr] & (deficit[ptr] >= DW'(PSIZE));
    if (serve) begin
      gnt      = NUM_REQS'(onehot(32'(ptr)));
      data_out = heads[ptr];
    end
    if ((nxt == ptr) && !reqs[ptr]) nxt_base = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
      for (int i = 0; i < NUM_REQS; i++)
        deficit[i] <= (i == 0) ? DW'(quanta[0]) : '0;
    end else if (!hold) begin
      if (serve) begin
        deficit[ptr] <= deficit[ptr] - DW'(PSIZE);
      end else begin
        ptr <= nxt;
        if (!reqs[ptr]) deficit[ptr] <= '0;
        if (nxt_base < DW'(PSIZE)) deficit[nxt] <= nxt_base + DW'(quanta[nxt]);
      end
    end
  end

endmodule

// File: tb/tb_dwrr_queue_sched.sv
// Scoreboard bench: a queue-based DWRR model predicts every cycle's outputs; a monitor compares.
module tb_dwrr_queue_sched;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int QW = 8;
  localparam int PS = 8;
`ifdef DWRR_QUEUE_SCHED_BLK_EN
  localparam bit BLK_ON = 1'b1;
`else
  localparam bit BLK_ON = 1'b0;
`endif

  typedef struct packed {
    logic        chk;
    logic [31:0] cyc;
    logic [3:0]  gnt;
    logic [7:0]  dout;
    logic        vld;
    logic [3:0]  empty;
    logic [3:0]  full;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic blk = 1'b0;
  logic [NR-1:0]    push = '0;
  logic [NR*W-1:0]  flat_data_in = '0;
  logic [NR*QW-1:0] input_quantums = '0;
  logic [NR-1:0]    full, empty, gnt;
  logic [W-1:0]     data_out;
  logic             data_out_vld;

  always #5 clk = ~clk;

  dwrr_queue_sched #(.NUM_REQS(NR), .WIDTH(W), .DEPTH(D), .QWID(QW), .PSIZE(PS)) dut (
    .clk           (clk),
    .rst           (rst),
    .push          (push),
    .flat_data_in  (flat_data_in),
    .input_quantums(input_quantums),
`ifdef DWRR_QUEUE_SCHED_BLK_EN
    .blk           (blk),
`endif
    .full          (full),
    .empty         (empty),
    .gnt           (gnt),
    .data_out      (data_out),
    .data_out_vld  (data_out_vld)
  );

  // Reference model: plain queues and integer credits.
  logic [7:0] mq [NR][$];
  int         mdef [NR];
  int         mptr;
  bit         known = 1'b0;
  int         cyc = 0;
  exp_t       exp_q [$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [NR*QW-1:0] cur_q = '0;

  function automatic int quant(input logic [NR*QW-1:0] qv, input int i);
    return int'(qv[i*QW +: QW]);
  endfunction

  task automatic cycle(input logic r, input logic [NR-1:0] p, input logic [31:0] d, input logic b);
    exp_t e;
    bit   g;
    bit   be;
    int   sz [NR];
    int   nx;
    @(posedge clk);
    #1;
    rst = r; push = p; flat_data_in = d; input_quantums = cur_q; blk = b;
    be = b & BLK_ON;
    for (int i = 0; i < NR; i++) sz[i] = mq[i].size();
    g = !be && sz[mptr] > 0 && mdef[mptr] >= PS;
    e.chk  = known;
    e.cyc  = 32'(cyc);
    e.gnt  = g ? 4'(1 << mptr) : 4'h0;
    e.dout = g ? mq[mptr][0] : 8'h00;
    e.vld  = g;
    for (int i = 0; i < NR; i++) begin
      e.empty[i] = (sz[i] == 0);
      e.full[i]  = (sz[i] == D);
    end
    exp_q.push_back(e);
    cyc++;
    if (!r) begin
      for (int i = 0; i < NR; i++) begin
        mq[i].delete();
        mdef[i] = 0;
      end
      mptr = 0;
      mdef[0] = quant(cur_q, 0);
      known = 1'b1;
    end else begin
      if (g) begin
        void'(mq[mptr].pop_front());
        mdef[mptr] -= PS;
      end else if (!be) begin
        nx = (mptr + 1) % NR;
        if (sz[mptr] == 0) mdef[mptr] = 0;
        if (mdef[nx] < PS) mdef[nx] += quant(cur_q, nx);
        mptr = nx;
      end
      for (int i = 0; i < NR; i++)
        if (p[i] && sz[i] < D) mq[i].push_back(d[i*W +: W]);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, '0, $urandom, 1'b0);
  endtask

  // Monitor: compare each cycle's outputs against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          vectors++;
          if (gnt !== e.gnt || data_out !== e.dout || data_out_vld !== e.vld ||
              empty !== e.empty || full !== e.full) begin
            miscompares++;
            $display("FAIL cycle %0d outputs: got gnt=%h dout=%h vld=%b empty=%h full=%h, expected gnt=%h dout=%h vld=%b empty=%h full=%h",
                     e.cyc, gnt, data_out, data_out_vld, empty, full,
                     e.gnt, e.dout, e.vld, e.empty, e.full);
          end
        end
      end
    end
  end

  initial begin
    // Reset with pushes on every lane: reset must win.
    cur_q = '0;
    cycle(1'b0, 4'hF, $urandom, 1'b0);
    idle(2);

    // Order: q0 with quantum 24 and three words.
    cur_q = {8'd0, 8'd0, 8'd0, 8'd24};
    cycle(1'b0, '0, 0, 1'b0);
    cycle(1'b1, 4'b0001, 32'h11, 1'b0);
    cycle(1'b1, 4'b0001, 32'h22, 1'b0);
    cycle(1'b1, 4'b0001, 32'h33, 1'b0);
    idle(12);

    // Full: nine pushes into q1 with zero quanta.
    cur_q = '0;
    cycle(1'b0, '0, 0, 1'b0);
    for (int k = 0; k < 9; k++) cycle(1'b1, 4'b0010, 32'(8'h40 + k) << 8, 1'b0);
    idle(6);

    // Weighting 2:1 between q0 and q1.
    cur_q = {8'd0, 8'd0, 8'd8, 8'd16};
    cycle(1'b0, '0, 0, 1'b0);
    for (int k = 0; k < 8; k++) cycle(1'b1, 4'b0011, {16'h0, 8'hB0 + 8'(k), 8'hA0 + 8'(k)}, 1'b0);
    idle(40);

    // Idle forfeit: quantum 20 with a single word.
    cur_q = {8'd0, 8'd0, 8'd0, 8'd20};
    cycle(1'b0, '0, 0, 1'b0);
    cycle(1'b1, 4'b0001, 32'h5A, 1'b0);
    idle(20);
    cycle(1'b1, 4'b0001, 32'h5B, 1'b0);
    idle(20);

    // Block mid-backlog, then resume.
    cur_q = {8'd8, 8'd0, 8'd16, 8'd24};
    cycle(1'b0, '0, 0, 1'b0);
    for (int k = 0; k < 6; k++) cycle(1'b1, 4'b1101, $urandom, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b1, 4'b0000, 0, 1'b1);
    idle(30);

    // Randomised traffic with live quanta, occasional resets and back-pressure.
    for (int k = 0; k < 700; k++) begin
      if (k % 50 == 0)
        for (int i = 0; i < NR; i++) cur_q[i*QW +: QW] = 8'($urandom_range(0, 24));
      cycle(($urandom_range(0, 99) != 0), 4'($urandom), $urandom, ($urandom_range(0, 7) == 0));
    end
    idle(3);

    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending predictions, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dwrr_queue_sched.md
# dwrr_queue_sched

Multi-queue packet scheduler. NUM_REQS per-requestor FIFOs feed a deficit-weighted round-robin (DWRR) arbiter. Each cycle the arbiter grants at most one non-empty queue, and the granted queue's head word appears on a single shared output. The block sits between the requestor ingress ports and a single-word egress consumer. Its per-queue flags are exported for flow control.

## Interface
- NUM_REQS, 4: number of requestor queues (≥1).
- WIDTH, 8: data word width.
- DEPTH, 8: entries per FIFO; power of two.
- QWID, 8: width of each quantum.
- PSIZE, WIDTH: deficit cost of one packet; 1 ≤ PSIZE ≤ 2^QWID−1.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- push  in  NUM_REQS  per-queue write strobe.
- flat_data_in  in  NUM_REQS*WIDTH  queue i data is bits [(i+1)*WIDTH-1 : i*WIDTH].
- input_quantums  in  NUM_REQS*QWID  queue i quantum, packed the same way; sampled live.
- blk  in  1  egress back-pressure. Present only with the macro in Configuration.
- full  out  NUM_REQS  queue i holds DEPTH entries.
- empty  out  NUM_REQS  queue i holds 0 entries.
- gnt  out  NUM_REQS  one-hot-or-zero grant; the granted queue pops this cycle.
- data_out  out  WIDTH  head word of the granted queue; 0 when there is no grant.
- data_out_vld  out  1  |gnt.

## Operation
- Each FIFO:
  - First-word-fall-through: the head is visible combinationally.
  - Count register is $clog2(DEPTH)+1 bits; read and write pointers wrap modulo DEPTH.
  - Push is accepted iff !full. Push while full is dropped; state is unchanged.
  - Pop (gnt[i]) is accepted iff !empty. The arbiter never grants an empty queue.
  - Simultaneous push and pop on a non-full, non-empty queue leaves the count unchanged.
  - When full, a push in the same cycle as a pop is dropped, because full is evaluated before the pop.
- Requests: reqs[i] = ~empty[i].
- Arbiter state:
  - ptr: current queue index.
  - deficit[i]: QWID+1 bits each.
- Serve rule: gnt = onehot(ptr) when blk=0, reqs[ptr]=1 and deficit[ptr] ≥ PSIZE; otherwise 0.
- Grant cycle:
  - deficit[ptr] −= PSIZE.
  - ptr holds.
- Advance cycle (blk=0 and no grant):
  - nxt = (ptr+1) mod NUM_REQS.
  - ptr ← nxt.
  - deficit[nxt] += quantum[nxt].
  - If reqs[ptr]=0, deficit[ptr] ← 0, so an idle queue forfeits its credit.
  - When NUM_REQS=1, nxt = ptr; clear first, then add quantum.
- Quantum is added only on an advance and only when deficit < PSIZE. Deficit therefore never exceeds PSIZE−1+2^QWID−1, and it never overflows or underflows.
- Quantum 0 means the queue is never served.

## Timing
- Reset, applied when rst=0 at a clock edge:
  - All FIFOs become empty: empty all 1s, full 0.
  - ptr=0, deficit[0]=quantum[0], other deficits 0.
  - gnt=0, data_out=0, data_out_vld=0.
  - Reset has priority over push and pop in the same cycle. FIFO storage contents are not cleared.
- Push to earliest grant is 1 cycle: empty deasserts after the push edge, and gnt may assert in that next cycle.
- gnt, data_out and data_out_vld are combinational from registered state and blk. The pop commits at the same edge.
- Sustained throughput is 1 word per cycle while a queue holds credit. Each advance costs one idle cycle.

## Configuration
- DWRR_QUEUE_SCHED_BLK_EN defined: the blk port exists, and blk=1 forces gnt=0 and freezes ptr and all deficits. FIFO pushes continue.
- Macro undefined: no blk port; the arbiter behaves as blk=0.

## Structure
- Package dwrr_queue_sched_pkg:
  - Default parameter constants.
  - The count-width and deficit-width localparam formulas.
  - Function onehot(idx).
- One natural sub-module: sched_fifo, a parameterised FIFO instantiated NUM_REQS times via generate. The arbiter stays in the top module.

## Test plan
All tests use NUM_REQS=4, WIDTH=8, DEPTH=8, QWID=8, PSIZE=8.
- Reset: hold rst=0 for 1 cycle with push=4'hF → empty=4'hF, full=0, gnt=0, data_out_vld=0.
- Order: quantums {24,0,0,0}; push 0x11, 0x22, 0x33 into q0 → gnt=4'b0001 on 3 consecutive cycles with data_out 0x11, 0x22, 0x33, then empty[0]=1.
- Full: all quantums 0; push 9 words into q1 → full[1]=1 after the 8th push; the 9th is dropped; gnt stays 0.
- Weighting: quantums {16,8,0,0}; q0 and q1 preloaded with 8 words each → grant sequence per round is q0, q0, q1; totals are 2:1 until q1 drains.
- Idle forfeit: quantum0=20, one word in q0 → one grant, then the deficit is cleared to 0 when ptr leaves the empty q0.
- Block (macro on): assert blk mid-backlog for 5 cycles → gnt=0, deficits frozen; on release the sequence resumes exactly where it stopped.
